// File: rtl/dual_wb_commit.sv
`default_nettype none
// ============================================================================
// Module   : dual_wb_commit
// Brief    : Dual-lane writeback/commit stage with a 1-pair skid buffer,
//            same-destination resolution and a register busy scoreboard.
//            Optional commit counter enabled by macro WB_COMMIT_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dual_wb_commit #(
    parameter int REG_NUM = 32,
    parameter int AW      = 5,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic          mem1_we,
    input  logic [AW-1:0] mem1_wa,
    input  logic [DW-1:0] mem1_wd,
    input  logic          mem2_we,
    input  logic [AW-1:0] mem2_wa,
    input  logic [DW-1:0] mem2_wd,
    input  logic          wb_stall,
    output logic          inst1_we,
    output logic [AW-1:0] inst1_wa,
    output logic [DW-1:0] inst1_wd,
    output logic          inst2_we,
    output logic [AW-1:0] inst2_wa,
    output logic [DW-1:0] inst2_wd,
    input  logic          iss1_we,
    input  logic [AW-1:0] iss1_wa,
    input  logic          iss2_we,
    input  logic [AW-1:0] iss2_wa,
    input  logic [AW-1:0] q_ra0,
    input  logic [AW-1:0] q_ra1,
    input  logic [AW-1:0] q_ra2,
    input  logic [AW-1:0] q_ra3,
    output logic [3:0]    q_busy
`ifdef WB_COMMIT_CNT_EN
    ,
    output logic [31:0]   commit_cnt
`endif
);

    typedef struct packed {
        logic          we1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic          we2;
        logic [AW-1:0] wa2;
        logic [DW-1:0] wd2;
    } pair_t;

    pair_t               in_pair, src_pair;
    pair_t               skid_q, skid_d;
    pair_t               out_q, out_d;
    logic                skid_full_q, skid_full_d;
    logic [REG_NUM-1:0]  busy_q, busy_d;
    logic                xfer, load;

    // r0 writes are dropped; on equal destinations the younger lane wins.
    function automatic pair_t resolve(input pair_t p);
        pair_t r;
        r = p;
        if (r.wa1 == '0) r.we1 = 1'b0;
        if (r.wa2 == '0) r.we2 = 1'b0;
        if (r.we1 && r.we2 && (r.wa1 == r.wa2)) r.we1 = 1'b0;
        return r;
    endfunction

    assign in_pair  = '{we1: mem1_we, wa1: mem1_wa, wd1: mem1_wd,
                        we2: mem2_we, wa2: mem2_wa, wd2: mem2_wd};
    assign xfer     = mem_valid && !skid_full_q;
    assign src_pair = skid_full_q ? skid_q : in_pair;
    assign load     = !wb_stall && (skid_full_q || xfer);

    always_comb begin
        out_d       = out_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        if (!wb_stall) begin
            skid_full_d = 1'b0;
            out_d       = load ? resolve(src_pair) : '0;
        end else if (xfer) begin
            skid_d      = in_pair;
            skid_full_d = 1'b1;
        end
    end

    // Issue-side set is applied after commit-side clear so a newer writer wins.
    always_comb begin
        busy_d = busy_q;
        if (!wb_stall && out_q.we1) busy_d[out_q.wa1] = 1'b0;
        if (!wb_stall && out_q.we2) busy_d[out_q.wa2] = 1'b0;
        if (iss1_we) busy_d[iss1_wa] = 1'b1;
        if (iss2_we) busy_d[iss2_wa] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            out_q       <= '0;
            skid_q      <= '0;
            skid_full_q <= 1'b0;
            busy_q      <= '0;
        end else begin
            out_q       <= out_d;
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
            busy_q      <= busy_d;
        end
    end

`ifdef WB_COMMIT_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Counts the raw lane enables of every loaded pair, suppressed lanes included.
    always_comb begin
        cnt_d = cnt_q;
        if (load) cnt_d = cnt_q + {31'd0, src_pair.we1} + {31'd0, src_pair.we2};
    end

    always_ff @(posedge clk) begin
        if (resetn) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign commit_cnt = cnt_q;
`endif

    assign mem_ready = !skid_full_q;
    assign inst1_we  = out_q.we1;
    assign inst1_wa  = out_q.wa1;
    assign inst1_wd  = out_q.wd1;
    assign inst2_we  = out_q.we2;
    assign inst2_wa  = out_q.wa2;
    assign inst2_wd  = out_q.wd2;
    assign q_busy    = {busy_q[q_ra3], busy_q[q_ra2], busy_q[q_ra1], busy_q[q_ra0]};

endmodule
`default_nettype wire

// File: doc/dual_wb_commit.md
Name: dual_wb_commit

Overview:
- Writeback/commit stage of the dual-issue pipeline: accepts a pair of results from MEM and drives the two register-file write ports (inst1_*/inst2_*) one cycle later.
- Resolves same-destination conflicts so that the younger lane wins.
- Maintains a register busy scoreboard: set at issue, cleared at commit. The issue stage uses it for RAW hazard stalls.

Parameters:
- REG_NUM, 32, number of architectural registers.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  synchronous reset, active-high (1 = reset), sampled on posedge clk.
- mem_valid  in  1  result pair valid.
- mem_ready  out  1  stage can accept a pair.
- mem1_we / mem2_we  in  1  lane1 (older) / lane2 (younger) write enable.
- mem1_wa / mem2_wa  in  AW  destination register.
- mem1_wd / mem2_wd  in  DW  result data.
- wb_stall  in  1  downstream hold; committed outputs must not change while it is 1.
- inst1_we / inst2_we  out  1  regfile write enables.
- inst1_wa / inst2_wa  out  AW  regfile write addresses.
- inst1_wd / inst2_wd  out  DW  regfile write data.
- iss1_we / iss2_we  in  1  issue-side destination allocation.
- iss1_wa / iss2_wa  in  AW  issued destination register.
- q_ra0..q_ra3  in  AW  scoreboard query addresses.
- q_busy  out  4  busy bit per query, bit n for q_ra n; combinational.

Behaviour:
- Reset: all outputs 0. Skid buffer empty. All busy bits 0. mem_ready = 1 in the cycle after reset deasserts.
- Handshake:
  - A pair transfers when mem_valid && mem_ready.
  - mem_ready = !skid_full.
- Output stage (registered):
  - When !wb_stall, the output register loads from the skid buffer if it is full, else from a transferring pair, else it loads all-zero enables.
  - Latency from transfer to inst*_we = 1 cycle with no stall.
  - When wb_stall = 1, outputs hold their values. A transferring pair goes into the 1-pair skid buffer, and skid_full is set.
  - The skid buffer drains on the first non-stall cycle. The incoming pair is not accepted that cycle, because mem_ready is 0.
- Conflict rules, applied when a pair is loaded into the output register:
  - Any lane with wa == 0 has its we forced to 0.
  - If both we = 1 and mem1_wa == mem2_wa, inst1_we is forced to 0; only lane2's data is written.
  - If both we = 0, the pair is still a valid transfer but produces no write.
- Scoreboard:
  - Clear: busy[inst1_wa] clears at the clock edge when inst1_we = 1 and !wb_stall. The same applies to lane 2.
  - Set: busy[issN_wa] is set on issN_we when issN_wa != 0. busy[0] is always 0.
  - Set and clear on the same register in the same cycle: set wins, because a newer writer is pending.
  - Both issue lanes targeting the same register: set once.
  - Lane1 cleared by the conflict rule: its busy bit is still cleared by lane2's write to the same address.
  - q_busy reflects registered state only; there is no same-cycle bypass.
- Reset mid-operation: skid contents are discarded, output enables go to 0, and the scoreboard is cleared in the same edge.

Optional Feature:
- Macro: WB_COMMIT_CNT_EN.
- When defined:
  - Adds output commit_cnt, 32 bits.
  - commit_cnt increments at each clock edge where the output register loads a new pair, by the number of lanes whose original mem*_we was 1. Lanes suppressed by the same-address rule count as committed; r0 writes count.
  - The counter wraps modulo 2^32 and resets to 0.
- When undefined: the port and the counter do not exist. All other behaviour is identical.

Test Plan:
- Basic commit: transfer mem1 (we=1, wa=3, wd=0x11) and mem2 (we=1, wa=4, wd=0x22) -> the next cycle inst1_we=1, wa=3, wd=0x11 and inst2_we=1, wa=4, wd=0x22.
- Same destination: mem1 and mem2 both write wa=7, wd 0xA / 0xB -> inst1_we=0; inst2 writes 7 with 0xB.
- r0 write: mem1 wa=0, we=1 -> inst1_we=0.
- Stall with skid:
  - Pair P1 transfers; wb_stall=1 for 2 cycles while P2 is offered -> outputs hold P1 and P2 enters the skid.
  - mem_ready=0 during the stall.
  - After the stall drops, outputs show P2 and mem_ready returns to 1.
- Scoreboard sequence:
  - iss1 wa=5 -> q_busy for 5 = 1 the next cycle.
  - Commit wa=5 while iss2 wa=5 is in the same cycle -> busy stays 1.
  - A later commit of 5 -> 0.
  - A query of r0 is always 0.
- Reset mid-stall with skid full -> all enables 0, mem_ready=1, all q_busy=0 the next cycle. With WB_COMMIT_CNT_EN defined, commit_cnt=0.
